// File: rtl/mem_arbiter_nport_if.sv
// Requester-side bus of the N-port memory arbiter: per-channel request
// strobes and packed address/data lanes, plus registered responses.
interface mem_arbiter_nport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CH     = 3
);
    logic [NUM_CH-1:0]            ch_en;
    logic [NUM_CH-1:0]            ch_wr_en;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata;
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH-1:0]            ch_busy;

    modport master (
        output ch_en, ch_wr_en, ch_addr, ch_wdata,
        input  ch_rdata, ch_valid, ch_busy
    );

    modport slave (
        input  ch_en, ch_wr_en, ch_addr, ch_wdata,
        output ch_rdata, ch_valid, ch_busy
    );
endinterface

// File: rtl/mem_arbiter_nport.sv
// Round-robin arbiter granting up to MEM_PORTS of NUM_CH requesters per cycle
// into one shared word memory; losers wait in a one-entry per-channel buffer.
module mem_arbiter_nport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CH     = 3,
    parameter int MEM_PORTS  = 2,
    parameter int MEM_DEPTH  = 1024
) (
    input logic clk,
    input logic rst,
    mem_arbiter_nport_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CH_W  = $clog2(NUM_CH);

    logic [DATA_WIDTH-1:0]        mem [MEM_DEPTH];

    logic [NUM_CH-1:0]            pend_en;
    logic [NUM_CH-1:0]            pend_wr;
    logic [IDX_W-1:0]             pend_idx [NUM_CH];
    logic [DATA_WIDTH-1:0]        pend_wdata [NUM_CH];
    logic [CH_W-1:0]              rr_ptr;
    logic [CH_W-1:0]              rr_next;
    logic [NUM_CH-1:0]            valid_q;
    logic [NUM_CH*DATA_WIDTH-1:0] rdata_q;

    logic [NUM_CH-1:0]            cand;
    logic [NUM_CH-1:0]            cand_wr;
    logic [IDX_W-1:0]             cand_idx [NUM_CH];
    logic [DATA_WIDTH-1:0]        cand_wdata [NUM_CH];
    logic [NUM_CH-1:0]            grant;
    logic [CH_W-1:0]              scan_ch [NUM_CH];

    // Only the index bits of each address reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ch_addr;

    // busy mirrors the pending buffer, so a held entry masks any new strobe.
    always_comb begin
        cand       = '0;
        cand_wr    = '0;
        cand_idx   = '{default: '0};
        cand_wdata = '{default: '0};
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_en[i]) begin
                cand[i]       = 1'b1;
                cand_wr[i]    = pend_wr[i];
                cand_idx[i]   = pend_idx[i];
                cand_wdata[i] = pend_wdata[i];
            end else begin
                cand[i]       = bus.ch_en[i];
                cand_wr[i]    = bus.ch_wr_en[i];
                cand_idx[i]   = bus.ch_addr[i*ADDR_WIDTH +: IDX_W];
                cand_wdata[i] = bus.ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        int              pos;
        int              cnt;
        logic [CH_W-1:0] sel;
        logic [CH_W-1:0] last;
        grant   = '0;
        rr_next = rr_ptr;
        scan_ch = '{default: '0};
        pos     = 0;
        cnt     = 0;
        sel     = '0;
        last    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_CH) pos = pos - NUM_CH;
            sel        = CH_W'(pos);
            scan_ch[k] = sel;
            if (cand[sel] && cnt < MEM_PORTS) begin
                grant[sel] = 1'b1;
                cnt        = cnt + 1;
                last       = sel;
            end
        end
        if (cnt != 0) rr_next = (last == CH_W'(NUM_CH - 1)) ? '0 : last + 1'b1;
    end

    // Writes in scan order; the last non-blocking write to an index wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (grant[scan_ch[k]] && cand_wr[scan_ch[k]])
                    mem[cand_idx[scan_ch[k]]] <= cand_wdata[scan_ch[k]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            pend_en    <= '0;
            pend_wr    <= '0;
            valid_q    <= '0;
            rdata_q    <= '0;
            pend_idx   <= '{default: '0};
            pend_wdata <= '{default: '0};
        end else begin
            rr_ptr  <= rr_next;
            valid_q <= grant;
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant[i]) begin
                    pend_en[i] <= 1'b0;
                    rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <=
                        cand_wr[i] ? cand_wdata[i] : mem[cand_idx[i]];
                end else if (cand[i] && !pend_en[i]) begin
                    pend_en[i]    <= 1'b1;
                    pend_wr[i]    <= cand_wr[i];
                    pend_idx[i]   <= cand_idx[i];
                    pend_wdata[i] <= cand_wdata[i];
                end
            end
        end
    end

    assign bus.ch_valid = valid_q;
    assign bus.ch_busy  = pend_en;
    assign bus.ch_rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Bench for mem_arbiter_nport (3 channels, 2 ports): vector table replayed
// through a scoreboard, then rotation and mid-operation reset sequences.
module tb_mem_arbiter_nport;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_nport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_CH(3)) bus ();

    mem_arbiter_nport #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_CH(3), .MEM_PORTS(2), .MEM_DEPTH(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit               rst_first;
        logic [2:0]       en;
        logic [2:0]       wr;
        logic [2:0][15:0] addr;
        logic [2:0][31:0] wdata;
        logic [2:0]       exp_valid;
        logic [2:0]       exp_busy;
        logic [2:0][31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [2:0]       valid;
        logic [2:0]       busy;
        logic [2:0][31:0] rdata;
        string            tag;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(bit r, logic [2:0] en, logic [2:0] wr, logic [47:0] a,
                                logic [95:0] d, logic [2:0] ev, logic [2:0] eb, logic [95:0] rd);
        vec_t v;
        v.rst_first = r;
        v.en        = en;
        v.wr        = wr;
        v.addr      = a;
        v.wdata     = d;
        v.exp_valid = ev;
        v.exp_busy  = eb;
        v.exp_rdata = rd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic drive(logic [2:0] en, logic [2:0] wr, logic [47:0] a, logic [95:0] d);
        bus.ch_en    = en;
        bus.ch_wr_en = wr;
        bus.ch_addr  = a;
        bus.ch_wdata = d;
    endtask

    task automatic idle();
        drive(3'b000, 3'b000, '0, '0);
    endtask

    task automatic expect_push(logic [2:0] v, logic [2:0] b, logic [95:0] rd, string tag);
        exp_t e;
        e.valid = v;
        e.busy  = b;
        e.rdata = rd;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // Advance one edge and compare the outputs it produced at the negedge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue want an entry");
            return;
        end
        e = sb.pop_front();
        check({e.tag, " valid"}, 32'(bus.ch_valid), 32'(e.valid));
        check({e.tag, " busy"}, 32'(bus.ch_busy), 32'(e.busy));
        for (int i = 0; i < 3; i++)
            if (e.valid[i])
                check($sformatf("%s rdata%0d", e.tag, i), bus.ch_rdata[i*32 +: 32], e.rdata[i]);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] pat [6];
    int         nvalid [3];

    initial begin
        rst = 1'b1;
        idle();

        vt.push_back(mk(0, 3'b001, 3'b001, {16'h0, 16'h0, 16'h0012}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 3'b000, {32'h0, 32'h0, 32'hDEADBEEF}));
        vt.push_back(mk(0, 3'b001, 3'b000, {16'h0, 16'h0, 16'h0012}, '0, 3'b001, 3'b000, {32'h0, 32'h0, 32'hDEADBEEF}));
        vt.push_back(mk(1, 3'b111, 3'b111, {16'h3000, 16'h4000, 16'h2000}, {32'd3, 32'd2, 32'd1}, 3'b011, 3'b100, {32'h0, 32'd2, 32'd1}));
        vt.push_back(mk(0, 3'b000, 3'b000, '0, '0, 3'b100, 3'b000, {32'd3, 32'h0, 32'h0}));
        vt.push_back(mk(0, 3'b010, 3'b000, {16'h0, 16'h0000, 16'h0}, '0, 3'b010, 3'b000, {32'h0, 32'd3, 32'h0}));
        vt.push_back(mk(0, 3'b100, 3'b100, {16'h0010, 16'h0, 16'h0}, {32'h5555, 32'h0, 32'h0}, 3'b100, 3'b000, {32'h5555, 32'h0, 32'h0}));
        vt.push_back(mk(0, 3'b011, 3'b001, {16'h0, 16'h0010, 16'h0010}, {32'h0, 32'h0, 32'hAAAA}, 3'b011, 3'b000, {32'h0, 32'h5555, 32'hAAAA}));
        vt.push_back(mk(0, 3'b100, 3'b000, {16'h0010, 16'h0, 16'h0}, '0, 3'b100, 3'b000, {32'hAAAA, 32'h0, 32'h0}));
        vt.push_back(mk(0, 3'b011, 3'b011, {16'h0, 16'h0020, 16'h0020}, {32'h0, 32'h22, 32'h11}, 3'b011, 3'b000, {32'h0, 32'h22, 32'h11}));
        vt.push_back(mk(0, 3'b100, 3'b000, {16'h0020, 16'h0, 16'h0}, '0, 3'b100, 3'b000, {32'h22, 32'h0, 32'h0}));
        vt.push_back(mk(0, 3'b010, 3'b000, {16'h0, 16'h0020, 16'h0}, '0, 3'b010, 3'b000, {32'h0, 32'h22, 32'h0}));
        vt.push_back(mk(0, 3'b101, 3'b101, {16'h0030, 16'h0, 16'h0030}, {32'hC2, 32'h0, 32'hA0}, 3'b101, 3'b000, {32'hC2, 32'h0, 32'hA0}));
        vt.push_back(mk(0, 3'b010, 3'b000, {16'h0, 16'h0030, 16'h0}, '0, 3'b010, 3'b000, {32'h0, 32'hA0, 32'h0}));
        vt.push_back(mk(0, 3'b001, 3'b001, {16'h0, 16'h0, 16'h0405}, {32'h0, 32'h0, 32'd7}, 3'b001, 3'b000, {32'h0, 32'h0, 32'd7}));
        vt.push_back(mk(0, 3'b010, 3'b000, {16'h0, 16'h0005, 16'h0}, '0, 3'b010, 3'b000, {32'h0, 32'd7, 32'h0}));
        vt.push_back(mk(0, 3'b100, 3'b000, {16'h0005, 16'h0, 16'h0}, '0, 3'b100, 3'b000, {32'd7, 32'h0, 32'h0}));
        vt.push_back(mk(0, 3'b111, 3'b100, {16'h0005, 16'h0005, 16'h0005}, {32'h99, 32'h0, 32'h0}, 3'b011, 3'b100, {32'h0, 32'd7, 32'd7}));
        vt.push_back(mk(0, 3'b100, 3'b100, {16'h0005, 16'h0, 16'h0}, {32'hBAD, 32'h0, 32'h0}, 3'b100, 3'b000, {32'h99, 32'h0, 32'h0}));
        vt.push_back(mk(0, 3'b000, 3'b000, '0, '0, 3'b000, 3'b000, '0));
        vt.push_back(mk(0, 3'b001, 3'b000, {16'h0, 16'h0, 16'h0005}, '0, 3'b001, 3'b000, {32'h0, 32'h0, 32'h99}));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset valid", 32'(bus.ch_valid), 32'h0);
        check("reset busy", 32'(bus.ch_busy), 32'h0);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset rdata%0d", i), bus.ch_rdata[i*32 +: 32], 32'h0);

        for (int n = 0; n < vt.size(); n++) begin
            if (vt[n].rst_first) do_reset();
            drive(vt[n].en, vt[n].wr, vt[n].addr, vt[n].wdata);
            expect_push(vt[n].exp_valid, vt[n].exp_busy, vt[n].exp_rdata, $sformatf("vec%0d", n));
            cycle();
        end
        idle();

        // Rotation: everyone reads 0x0005 (holds 0x99) whenever not busy.
        pat = '{3'b011, 3'b101, 3'b110, 3'b011, 3'b101, 3'b110};
        nvalid = '{0, 0, 0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(~bus.ch_busy, 3'b000, {16'h0005, 16'h0005, 16'h0005}, '0);
            expect_push(pat[c], ~pat[c], {32'h99, 32'h99, 32'h99}, $sformatf("rot%0d", c));
            cycle();
            for (int i = 0; i < 3; i++) if (bus.ch_valid[i]) nvalid[i]++;
        end
        idle();
        expect_push(3'b001, 3'b000, {32'h0, 32'h0, 32'h99}, "rot drain");
        cycle();
        for (int i = 0; i < 3; i++)
            check($sformatf("rot count%0d", i), 32'(nvalid[i]), 32'd4);

        // Reset while ch2 holds a pending read.
        do_reset();
        drive(3'b111, 3'b000, {16'h0005, 16'h0005, 16'h0005}, '0);
        expect_push(3'b011, 3'b100, {32'h0, 32'h99, 32'h99}, "pre-rst");
        cycle();
        idle();
        rst = 1'b1;
        #1;
        check("async rst valid", 32'(bus.ch_valid), 32'h0);
        check("async rst busy", 32'(bus.ch_busy), 32'h0);
        for (int i = 0; i < 3; i++)
            check($sformatf("async rst rdata%0d", i), bus.ch_rdata[i*32 +: 32], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            expect_push(3'b000, 3'b000, '0, "post-rst idle");
            cycle();
        end
        drive(3'b111, 3'b000, {16'h0005, 16'h0005, 16'h0005}, '0);
        expect_push(3'b011, 3'b100, {32'h0, 32'h99, 32'h99}, "post-rst first");
        cycle();
        idle();
        expect_push(3'b100, 3'b000, {32'h99, 32'h0, 32'h0}, "post-rst drain");
        cycle();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
